// File: rtl/id_pipe.sv
// MIPS decode stage with N-source operand forwarding, load-use hazard detection and a registered ID/EX stage.
// Optional stall counter output is built when ID_STALL_CNT_EN is defined.
module id_pipe #(
    parameter int DATA_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int FWD_PORTS = 2,
    parameter int AOP_W     = 8,
    parameter int ASEL_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid,
    output logic                         id_ready,
    input  logic [31:0]                  pc_id,
    input  logic [31:0]                  inst_id,
    input  logic                         flush,
    output logic                         reg1_re,
    output logic                         reg2_re,
    output logic [RADDR_W-1:0]           reg1_addr,
    output logic [RADDR_W-1:0]           reg2_addr,
    input  logic [DATA_W-1:0]            reg1_data,
    input  logic [DATA_W-1:0]            reg2_data,
    input  logic [FWD_PORTS-1:0]         fwd_we,
    input  logic [FWD_PORTS-1:0]         fwd_is_load,
    input  logic [FWD_PORTS*RADDR_W-1:0] fwd_addr,
    input  logic [FWD_PORTS*DATA_W-1:0]  fwd_data,
    input  logic                         ex_ready,
    output logic                         ex_valid,
    output logic [AOP_W-1:0]             aluop_o,
    output logic [ASEL_W-1:0]            alusel_o,
    output logic [DATA_W-1:0]            reg1_o,
    output logic [DATA_W-1:0]            reg2_o,
    output logic [RADDR_W-1:0]           wr_addr_o,
    output logic                         reg_we_o,
    output logic                         inst_invalid_o,
    output logic [31:0]                  pc_o
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt_o
`endif
);

    localparam logic [AOP_W-1:0]  EXE_NOP_OP    = AOP_W'(8'b0000_0000);
    localparam logic [AOP_W-1:0]  EXE_AND_OP    = AOP_W'(8'b0010_0100);
    localparam logic [AOP_W-1:0]  EXE_OR_OP     = AOP_W'(8'b0010_0101);
    localparam logic [AOP_W-1:0]  EXE_XOR_OP    = AOP_W'(8'b0010_0110);
    localparam logic [AOP_W-1:0]  EXE_NOR_OP    = AOP_W'(8'b0010_0111);
    localparam logic [ASEL_W-1:0] EXE_RES_NOP   = ASEL_W'(3'b000);
    localparam logic [ASEL_W-1:0] EXE_RES_LOGIC = ASEL_W'(3'b001);

    logic [RADDR_W-1:0] fwd_addr_a [FWD_PORTS];
    logic [DATA_W-1:0]  fwd_data_a [FWD_PORTS];

    generate
        for (genvar gi = 0; gi < FWD_PORTS; gi++) begin : g_fwd_unpack
            assign fwd_addr_a[gi] = fwd_addr[gi*RADDR_W +: RADDR_W];
            assign fwd_data_a[gi] = fwd_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [5:0]         opcode;
    logic [4:0]         sa;
    logic [5:0]         funct;
    logic [AOP_W-1:0]   aluop_d;
    logic [ASEL_W-1:0]  alusel_d;
    logic [RADDR_W-1:0] wr_addr_d;
    logic               reg_we_d;
    logic               invalid_d;
    logic [DATA_W-1:0]  imm;

    assign opcode = inst_id[31:26];
    assign sa     = inst_id[10:6];
    assign funct  = inst_id[5:0];

    always_comb begin
        aluop_d   = EXE_NOP_OP;
        alusel_d  = EXE_RES_NOP;
        reg1_re   = 1'b0;
        reg2_re   = 1'b0;
        reg1_addr = RADDR_W'(inst_id[25:21]);
        reg2_addr = RADDR_W'(inst_id[20:16]);
        wr_addr_d = RADDR_W'(inst_id[15:11]);
        reg_we_d  = 1'b0;
        invalid_d = 1'b1;
        imm       = '0;
        if (inst_id == 32'h0) begin
            invalid_d = 1'b0;
        end else begin
            case (opcode)
                6'h00: begin
                    if (sa == 5'd0) begin
                        case (funct)
                            6'h24, 6'h25, 6'h26, 6'h27: begin
                                case (funct)
                                    6'h24:   aluop_d = EXE_AND_OP;
                                    6'h25:   aluop_d = EXE_OR_OP;
                                    6'h26:   aluop_d = EXE_XOR_OP;
                                    default: aluop_d = EXE_NOR_OP;
                                endcase
                                alusel_d  = EXE_RES_LOGIC;
                                reg1_re   = 1'b1;
                                reg2_re   = 1'b1;
                                reg_we_d  = 1'b1;
                                invalid_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    case (opcode)
                        6'h0C:   aluop_d = EXE_AND_OP;
                        6'h0E:   aluop_d = EXE_XOR_OP;
                        default: aluop_d = EXE_OR_OP;
                    endcase
                    alusel_d  = EXE_RES_LOGIC;
                    reg1_re   = 1'b1;
                    wr_addr_d = RADDR_W'(inst_id[20:16]);
                    reg_we_d  = 1'b1;
                    invalid_d = 1'b0;
                    // LUI is an OR against rs ($0) with the immediate pre-shifted into the upper half
                    imm = (opcode == 6'h0F) ? DATA_W'({inst_id[15:0], 16'h0000})
                                            : DATA_W'(inst_id[15:0]);
                end
                default: ;
            endcase
        end
    end

    logic [DATA_W-1:0] op1_d;
    logic [DATA_W-1:0] op2_d;
    logic              ld1;
    logic              ld2;

    // Scan from the oldest port down so the youngest matching source wins
    always_comb begin
        op1_d = reg1_data;
        op2_d = reg2_data;
        ld1   = 1'b0;
        ld2   = 1'b0;
        for (int k = FWD_PORTS - 1; k >= 0; k--) begin
            if (fwd_we[k] && fwd_addr_a[k] == reg1_addr) begin
                op1_d = fwd_data_a[k];
                ld1   = fwd_is_load[k];
            end
            if (fwd_we[k] && fwd_addr_a[k] == reg2_addr) begin
                op2_d = fwd_data_a[k];
                ld2   = fwd_is_load[k];
            end
        end
        if (!reg1_re) begin
            op1_d = imm;
            ld1   = 1'b0;
        end
        if (!reg2_re) begin
            op2_d = imm;
            ld2   = 1'b0;
        end
    end

    logic hazard;
    logic hold;
    logic load_insn;
    logic stall_inc;

    assign hazard    = if_valid && ((reg1_re && ld1) || (reg2_re && ld2));
    assign hold      = !flush && !ex_ready;
    assign load_insn = !flush && ex_ready && !hazard && if_valid;
    assign stall_inc = !flush && ex_ready && hazard;
    assign id_ready  = flush || (ex_ready && !hazard);

    logic               ex_valid_q;
    logic [AOP_W-1:0]   aluop_q;
    logic [ASEL_W-1:0]  alusel_q;
    logic [DATA_W-1:0]  reg1_q;
    logic [DATA_W-1:0]  reg2_q;
    logic [RADDR_W-1:0] wr_addr_q;
    logic               reg_we_q;
    logic               invalid_q;
    logic [31:0]        pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            aluop_q    <= EXE_NOP_OP;
            alusel_q   <= EXE_RES_NOP;
            reg1_q     <= '0;
            reg2_q     <= '0;
            wr_addr_q  <= '0;
            reg_we_q   <= 1'b0;
            invalid_q  <= 1'b0;
            pc_q       <= '0;
        end else if (!hold) begin
            ex_valid_q <= load_insn;
            aluop_q    <= load_insn ? aluop_d   : EXE_NOP_OP;
            alusel_q   <= load_insn ? alusel_d  : EXE_RES_NOP;
            reg1_q     <= load_insn ? op1_d     : '0;
            reg2_q     <= load_insn ? op2_d     : '0;
            wr_addr_q  <= load_insn ? wr_addr_d : '0;
            reg_we_q   <= load_insn && reg_we_d;
            invalid_q  <= load_insn && invalid_d;
            pc_q       <= load_insn ? pc_id     : 32'h0;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign reg1_o         = reg1_q;
    assign reg2_o         = reg2_q;
    assign wr_addr_o      = wr_addr_q;
    assign reg_we_o       = reg_we_q;
    assign inst_invalid_o = invalid_q;
    assign pc_o           = pc_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_inc && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = stall_inc;
`endif

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: driver pushes expected ID/EX contents, a negedge monitor pops and compares on transfer.
module tb_id_pipe;

    localparam logic [7:0] OR_OP  = 8'h25;
    localparam logic [7:0] AND_OP = 8'h24;
    localparam logic [7:0] XOR_OP = 8'h26;
    localparam logic [7:0] NOR_OP = 8'h27;
    localparam logic [2:0] LOGIC  = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        flush;
    logic        reg1_re, reg2_re;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic [1:0]  fwd_we, fwd_is_load;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wr_addr_o;
    logic        reg_we_o;
    logic        inst_invalid_o;
    logic [31:0] pc_o;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    id_pipe dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .id_ready(id_ready),
        .pc_id(pc_id), .inst_id(inst_id), .flush(flush),
        .reg1_re(reg1_re), .reg2_re(reg2_re), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
        .reg1_data(reg1_data), .reg2_data(reg2_data),
        .fwd_we(fwd_we), .fwd_is_load(fwd_is_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .aluop_o(aluop_o), .alusel_o(alusel_o),
        .reg1_o(reg1_o), .reg2_o(reg2_o), .wr_addr_o(wr_addr_o), .reg_we_o(reg_we_o),
        .inst_invalid_o(inst_invalid_o), .pc_o(pc_o)
`ifdef ID_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  aop;
        logic [2:0]  asel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wr;
        logic        we;
        logic        inv;
        logic        ops;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] aop, input logic [2:0] asel,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wr,
                                input logic we, input logic inv, input logic ops, input logic [31:0] pc);
        exp_t e;
        e.aop = aop; e.asel = asel; e.r1 = r1; e.r2 = r2; e.wr = wr;
        e.we = we; e.inv = inv; e.ops = ops; e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    // Monitor: a transfer into EX happens at the next edge whenever ex_valid && ex_ready
    always @(negedge clk) begin
        if (ex_valid === 1'b1 && ex_ready === 1'b1) begin
            if (q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_output: got pc %h expected no transfer", pc_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_aluop", 32'(aluop_o), 32'(e.aop));
                chk("mon_alusel", 32'(alusel_o), 32'(e.asel));
                chk("mon_reg_we", 32'(reg_we_o), 32'(e.we));
                chk("mon_invalid", 32'(inst_invalid_o), 32'(e.inv));
                chk("mon_pc", pc_o, e.pc);
                if (e.ops) begin
                    chk("mon_reg1", reg1_o, e.r1);
                    chk("mon_reg2", reg2_o, e.r2);
                    chk("mon_wr_addr", 32'(wr_addr_o), 32'(e.wr));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        fwd_we = '0; fwd_is_load = '0; fwd_addr = '0; fwd_data = '0;
    endtask

    task automatic set_fwd(input int k, input logic we, input logic ld,
                           input logic [4:0] a, input logic [31:0] d);
        fwd_we[k] = we;
        fwd_is_load[k] = ld;
        fwd_addr[k*5 +: 5] = a;
        fwd_data[k*32 +: 32] = d;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] d1, input logic [31:0] d2);
        if_valid = 1'b1; pc_id = pc; inst_id = inst; reg1_data = d1; reg2_data = d2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        pc_id = '0; inst_id = '0; reg1_data = '0; reg2_data = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluop", 32'(aluop_o), 32'd0);
        chk("rst_alusel", 32'(alusel_o), 32'd0);
        chk("rst_reg_we", 32'(reg_we_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        rst = 1'b0;

        // ORI $1,$0,0x1100
        issue(32'h100, itype(6'h0D, 5'd0, 5'd1, 16'h1100), 32'h0, 32'hDEAD_BEEF);
        #1 chk("ori_ready", 32'(id_ready), 32'd1);
        q.push_back(mk(OR_OP, LOGIC, 32'h0, 32'h0000_1100, 5'd1, 1'b1, 1'b0, 1'b1, 32'h100));
        step();

        // OR $3,$1,$2: youngest forwarding port wins
        issue(32'h104, rtype(5'd1, 5'd2, 5'd3, 6'h25), 32'h1111_1111, 32'h2222_2222);
        set_fwd(0, 1'b1, 1'b0, 5'd1, 32'hAAAA_0000);
        set_fwd(1, 1'b1, 1'b0, 5'd1, 32'h0000_5555);
        #1 chk("or_ready", 32'(id_ready), 32'd1);
        chk("or_reg1_addr", 32'(reg1_addr), 32'd1);
        chk("or_reg2_addr", 32'(reg2_addr), 32'd2);
        q.push_back(mk(OR_OP, LOGIC, 32'hAAAA_0000, 32'h2222_2222, 5'd3, 1'b1, 1'b0, 1'b1, 32'h104));
        step();

        // ANDI $4,$2,0xFF against a load in flight on $2
        clear_in();
        issue(32'h108, itype(6'h0C, 5'd2, 5'd4, 16'h00FF), 32'h9999_9999, 32'h0);
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
        #1 chk("haz_ready", 32'(id_ready), 32'd0);
        step();
        chk("haz_bubble", 32'(ex_valid), 32'd0);
        chk("haz_bubble_we", 32'(reg_we_o), 32'd0);
`ifdef ID_STALL_CNT_EN
        chk("haz_stall_cnt", stall_cnt, 32'd1);
`endif
        set_fwd(0, 1'b1, 1'b0, 5'd2, 32'h0000_1234);
        #1 chk("haz_retry_ready", 32'(id_ready), 32'd1);
        q.push_back(mk(AND_OP, LOGIC, 32'h0000_1234, 32'h0000_00FF, 5'd4, 1'b1, 1'b0, 1'b1, 32'h108));
        step();

        // Back-pressure: XORI A accepted, XORI B waits three cycles
        clear_in();
        step();
        issue(32'h10C, itype(6'h0E, 5'd7, 5'd6, 16'h0F0F), 32'hFFFF_0000, 32'h0);
        #1 chk("xa_ready", 32'(id_ready), 32'd1);
        q.push_back(mk(XOR_OP, LOGIC, 32'hFFFF_0000, 32'h0000_0F0F, 5'd6, 1'b1, 1'b0, 1'b1, 32'h10C));
        step();
        issue(32'h110, itype(6'h0E, 5'd9, 5'd8, 16'h00F0), 32'h1234_5678, 32'h0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_ready", 32'(id_ready), 32'd0);
            chk("hold_ex_valid", 32'(ex_valid), 32'd1);
            chk("hold_reg2", reg2_o, 32'h0000_0F0F);
            chk("hold_pc", pc_o, 32'h10C);
            step();
        end
        ex_ready = 1'b1;
        #1 chk("xb_ready", 32'(id_ready), 32'd1);
        q.push_back(mk(XOR_OP, LOGIC, 32'h1234_5678, 32'h0000_00F0, 5'd8, 1'b1, 1'b0, 1'b1, 32'h110));
        step();
        clear_in();
        step();

        // Flush beats both back-pressure and a hazard
        issue(32'h114, itype(6'h0C, 5'd2, 5'd4, 16'h00FF), 32'h0, 32'h0);
        set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
        flush = 1'b1;
        ex_ready = 1'b0;
        #1 chk("flush_ready", 32'(id_ready), 32'd1);
        step();
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
`ifdef ID_STALL_CNT_EN
        chk("flush_stall_cnt", stall_cnt, 32'd1);
`endif
        clear_in();

        // Unrecognised opcode 0x3F
        issue(32'h118, 32'hFC00_0000, 32'h0, 32'h0);
        #1 chk("inv_ready", 32'(id_ready), 32'd1);
        q.push_back(mk(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h118));
        step();

        // LUI $5,0x8000
        issue(32'h11C, itype(6'h0F, 5'd0, 5'd5, 16'h8000), 32'h0, 32'h0);
        #1 q.push_back(mk(OR_OP, LOGIC, 32'h0, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b1, 32'h11C));
        step();

        // NOR $10,$11,$12: port0 disabled, port1 supplies rt
        issue(32'h120, rtype(5'd11, 5'd12, 5'd10, 6'h27), 32'h0000_FFFF, 32'h7777_7777);
        set_fwd(0, 1'b0, 1'b0, 5'd12, 32'h0000_0BAD);
        set_fwd(1, 1'b1, 1'b0, 5'd12, 32'hF0F0_F0F0);
        #1 q.push_back(mk(NOR_OP, LOGIC, 32'h0000_FFFF, 32'hF0F0_F0F0, 5'd10, 1'b1, 1'b0, 1'b1, 32'h120));
        step();
        clear_in();

        // All-zero word is a legal NOP
        issue(32'h124, 32'h0, 32'h0, 32'h0);
        #1 q.push_back(mk(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h124));
        step();

        // Reset mid-stream
        issue(32'h128, itype(6'h0D, 5'd3, 5'd7, 16'h0001), 32'h0000_0010, 32'h0);
        #1 q.push_back(mk(OR_OP, LOGIC, 32'h0000_0010, 32'h0000_0001, 5'd7, 1'b1, 1'b0, 1'b1, 32'h128));
        step();
        issue(32'h12C, itype(6'h0D, 5'd3, 5'd7, 16'h0002), 32'h0, 32'h0);
        rst = 1'b1;
        step();
        chk("mrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("mrst_aluop", 32'(aluop_o), 32'd0);
        chk("mrst_reg_we", 32'(reg_we_o), 32'd0);
        chk("mrst_reg2", reg2_o, 32'd0);
        chk("mrst_pc", pc_o, 32'd0);
`ifdef ID_STALL_CNT_EN
        chk("mrst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        clear_in();
        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
